imem_fetch: RTL and testbench
=============================

IMEM_FETCH -- requirements
Module: imem_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, byte address of the first fetch after reset.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, instruction buffer entries (power of two, >=2).
REQ-003 SHALL have parameter ADDR_W, default 15, memory word-address width.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 mem_address  out  ADDR_W  word address to on-chip memory, equal to fetch_pc[ADDR_W+1:2].
REQ-007 mem_chipselect  out  1  read issue strobe.
REQ-008 mem_clken  out  1  memory clock enable, constant 1.
REQ-009 mem_write  out  1  constant 0; mem_byteenable  out  4  constant 4'hF.
REQ-010 mem_readdata  in  32  read data, valid exactly 1 cycle after the issue cycle.
REQ-011 redirect_valid  in  1  branch/trap redirect request.
REQ-012 redirect_pc  in  32  redirect target byte address.
REQ-013 inst_valid  out  1  instruction available to decode.
REQ-014 inst_ready  in  1  decode accepts the instruction.
REQ-015 inst_data  out  32  instruction word; inst_pc  out  32  its byte address.
REQ-016 misalign_fault  out  1  redirect target misaligned (present only with FETCH_MISALIGN_TRAP_EN).

Function
REQ-017 Internal fetch_pc SHALL hold the next address to issue and advance by 4 (modulo 2^32) on every issue cycle.
REQ-018 mem_chipselect SHALL be 1 only when (fifo_count + inflight) < FIFO_DEPTH and redirect_valid=0, using registered counts (no same-cycle pop credit).
REQ-019 Issue in cycle C SHALL write {fetch_pc_at_issue, mem_readdata} into the FIFO at the end of C+1; inst_valid SHALL be 1 in C+2 at the earliest.
REQ-020 inflight SHALL be 0 or 1; the response SHALL always be taken, never dropped for lack of space.
REQ-021 inst_valid SHALL equal FIFO non-empty, forced to 0 in any cycle with redirect_valid=1.
REQ-022 A pop SHALL occur on inst_valid & inst_ready; simultaneous push and pop SHALL keep count unchanged.
REQ-023 inst_data/inst_pc SHALL be stable while inst_valid=1 and inst_ready=0.
REQ-024 Redirect in cycle N SHALL flush the FIFO, discard any response arriving in N+1, and load fetch_pc=redirect_pc; first new issue in N+1, first new inst_valid in N+3.
REQ-025 Redirect SHALL take priority over issue, push and pop in the same cycle.
REQ-026 mem_address SHALL wrap modulo 2^ADDR_W words; fetch_pc SHALL wrap at 2^32 with no flag.
REQ-027 With consumer always ready, throughput SHALL be one instruction per cycle after initial latency.

Reset
REQ-028 On reset_n=0: fetch_pc=RESET_PC, FIFO empty, inflight=0, inst_valid=0, mem_chipselect=0, misalign_fault=0, all asynchronously.
REQ-029 Reset asserted mid-operation SHALL discard all buffered and in-flight data; first issue SHALL be in the first cycle after reset_n deasserts.

Configuration
REQ-030 Macro FETCH_MISALIGN_TRAP_EN defined: redirect_pc[1:0]!=0 SHALL set misalign_fault in N+1 (held until next redirect or reset), suppress issue until then, and keep inst_valid=0.
REQ-031 Macro undefined: redirect_pc[1:0] SHALL be forced to 0, no misalign_fault port exists.

Structure
REQ-032 Shared package fetch_pkg SHALL hold RESET_PC default, XLEN=32, instruction width, and the FIFO entry type {pc[31:0], inst[31:0]}.
REQ-033 FIFO SHALL be a sub-module fetch_fifo (synchronous, flush input, count output); issue/PC/kill logic remains in imem_fetch.

Verification
REQ-034 Reset release, memory word0=0x00000013, word1=0x00100093, inst_ready=1 -> inst_valid in cycle 2 with pc 0x0/0x00000013, cycle 3 pc 0x4/0x00100093.
REQ-035 inst_ready=0 for 10 cycles -> exactly FIFO_DEPTH issues, chipselect then 0, outputs stable; release -> in-order drain, no gap, no loss.
REQ-036 Redirect to 0x100 while response in flight and FIFO holding 3 entries -> no old pc ever appears; next inst_pc=0x100 in N+3.
REQ-037 fetch_pc=0x1FFFC, ADDR_W=15 -> mem_address 0x7FFF then 0x0000, inst_pc 0x1FFFC then 0x20000.
REQ-038 With FETCH_MISALIGN_TRAP_EN: redirect to 0x102 -> misalign_fault=1 in N+1, no chipselect, inst_valid=0; redirect to 0x200 clears it.
REQ-039 reset_n pulsed low while FIFO full -> all outputs at reset values immediately; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types and constants for the instruction fetch unit:
//               data widths, default reset PC and the buffer entry type.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    localparam int XLEN = 32;
    localparam int ILEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // One buffered instruction together with the byte address it came from
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] inst;
    } fetch_entry_t;

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_fifo
// Description : Synchronous instruction buffer with flush and occupancy count.
//               DEPTH must be a power of two so the pointers wrap naturally.
//               Flush wins over push and pop in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             push,
    input  fetch_entry_t     push_data,
    input  logic             pop,
    output fetch_entry_t     head,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             wr_en;
    logic             rd_en;

    // Pointer and count update; a flush empties the buffer outright
    always_comb begin
        wr_en    = push & ~flush;
        rd_en    = pop & ~flush & (count_q != '0);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (rd_en) rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(wr_en) - CNT_W'(rd_en);
        end
    end

    // Control state, cleared asynchronously
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Data storage needs no reset: the count guards every read
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= push_data;
    end

    assign head  = mem_q[rd_ptr_q];
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule : fetch_fifo
`default_nettype wire

// File: rtl/imem_fetch.sv
`default_nettype none
// ============================================================================
// Module      : imem_fetch
// Description : Instruction fetch from a 1-cycle-latency on-chip memory into a
//               small buffer, with redirect (branch/trap) flush.
//               Optional macro FETCH_MISALIGN_TRAP_EN: a misaligned redirect
//               target raises misalign_fault and stalls fetch until the next
//               redirect; without it the low two target bits are dropped.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int          FIFO_DEPTH = 4,
    parameter int          ADDR_W     = 15
) (
    input  logic              clk,
    input  logic              reset_n,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_chipselect,
    output logic              mem_clken,
    output logic              mem_write,
    output logic [3:0]        mem_byteenable,
    input  logic [31:0]       mem_readdata,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [31:0]       inst_data,
    output logic [31:0]       inst_pc
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic              misalign_fault
`endif
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic             inflight_q, inflight_d;
    logic [31:0]      inflight_pc_q, inflight_pc_d;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_empty;
    fetch_entry_t     fifo_head;
    fetch_entry_t     push_entry;
    logic [CNT_W:0]   occupancy;
    logic [31:0]      redirect_target;
    logic             issue_block;
    logic             issue;
    logic             push;
    logic             pop;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic             misalign_fault_q, misalign_fault_d;

    // A misaligned target is kept as-is; the fault flag blocks issue instead
    always_comb begin
        redirect_target  = redirect_pc;
        issue_block      = misalign_fault_q;
        misalign_fault_d = misalign_fault_q;
        if (redirect_valid) misalign_fault_d = |redirect_pc[1:0];
    end

    // Fault flag holds until the next redirect
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) misalign_fault_q <= 1'b0;
        else          misalign_fault_q <= misalign_fault_d;
    end

    assign misalign_fault = misalign_fault_q;
`else
    // Word-align the target silently
    always_comb begin
        redirect_target = redirect_pc & 32'hFFFF_FFFC;
        issue_block     = 1'b0;
    end
`endif

    // Issue credit uses registered counts only; a redirect kills issue, push and pop
    always_comb begin
        occupancy  = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight_q};
        issue      = reset_n & ~redirect_valid & ~issue_block
                   & (occupancy < (CNT_W+1)'(FIFO_DEPTH));
        push       = inflight_q & ~redirect_valid;
        inst_valid = ~fifo_empty & ~redirect_valid;
        pop        = inst_valid & inst_ready;
        push_entry = '{pc: inflight_pc_q, inst: mem_readdata};
    end

    // Next fetch address and in-flight tracking
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inflight_d    = issue;
        inflight_pc_d = inflight_pc_q;
        if (redirect_valid) begin
            fetch_pc_d = redirect_target;
        end else if (issue) begin
            fetch_pc_d    = fetch_pc_q + 32'd4;
            inflight_pc_d = fetch_pc_q;
        end
    end

    // Fetch state registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= RESET_PC;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (redirect_valid),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign mem_address    = fetch_pc_q[ADDR_W+1:2];
    assign mem_chipselect = issue;
    assign mem_clken      = 1'b1;
    assign mem_write      = 1'b0;
    assign mem_byteenable = 4'hF;
    assign inst_data      = fifo_head.inst;
    assign inst_pc        = fifo_head.pc;

endmodule : imem_fetch
`default_nettype wire

// File: tb/tb_imem_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_fetch
// Description : Directed self-checking bench for imem_fetch with a 1-cycle
//               memory model. Honours FETCH_MISALIGN_TRAP_EN if defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_fetch;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [14:0] mem_address;
    logic        mem_chipselect;
    logic        mem_clken;
    logic        mem_write;
    logic [3:0]  mem_byteenable;
    logic [31:0] mem_readdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        misalign_fault;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    imem_fetch dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .mem_address    (mem_address),
        .mem_chipselect (mem_chipselect),
        .mem_clken      (mem_clken),
        .mem_write      (mem_write),
        .mem_byteenable (mem_byteenable),
        .mem_readdata   (mem_readdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc)
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        .misalign_fault (misalign_fault)
`endif
    );

    // Memory contents as a function of word address
    function automatic logic [31:0] mem_word(input logic [14:0] a);
        if (a == 15'd0) return 32'h0000_0013;
        if (a == 15'd1) return 32'h0010_0093;
        return 32'hC0DE_0000 ^ {17'h0, a};
    endfunction

    // Read data valid exactly one cycle after the issue cycle, garbage otherwise
    always @(posedge clk) begin
        mem_readdata <= mem_chipselect ? mem_word(mem_address) : 32'hDEAD_BEEF;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic sample;
        @(negedge clk);
    endtask

    task automatic check_inst(input string tag, input logic [31:0] pc);
        logic [31:0] p;
        p = pc;
        check({tag, "_valid"}, inst_valid, 1'b1);
        check({tag, "_pc"},    inst_pc,    p);
        check({tag, "_data"},  inst_data,  mem_word(p[16:2]));
    endtask

    // Hold reset, check reset outputs, release so the caller sits in cycle 0
    task automatic start_reset(input logic ready);
        reset_n        = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        inst_ready     = ready;
        repeat (2) @(posedge clk);
        sample;
        check("rst_cs",    mem_chipselect, 1'b0);
        check("rst_valid", inst_valid,     1'b0);
        check("rst_clken", mem_clken,      1'b1);
        check("rst_write", mem_write,      1'b0);
        check("rst_be",    mem_byteenable, 4'hF);
`ifdef FETCH_MISALIGN_TRAP_EN
        check("rst_fault", misalign_fault, 1'b0);
`endif
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    // Redirect in the next cycle N, expect issue at N+1 and first inst at N+3
    task automatic redirect_seq(input string tag, input logic [31:0] target,
                                input logic [31:0] exp_pc);
        logic [31:0] p0;
        logic [31:0] p1;
        p0 = exp_pc;
        p1 = exp_pc + 32'd4;
        next_cycle;
        redirect_valid = 1'b1;
        redirect_pc    = target;
        sample;
        check({tag, "_n_valid"}, inst_valid,     1'b0);
        check({tag, "_n_cs"},    mem_chipselect, 1'b0);
        next_cycle;
        redirect_valid = 1'b0;
        inst_ready     = 1'b1;
        sample;
        check({tag, "_n1_cs"},   mem_chipselect, 1'b1);
        check({tag, "_n1_addr"}, mem_address,    p0[16:2]);
        check({tag, "_n1_valid"}, inst_valid,    1'b0);
        next_cycle;
        sample;
        check({tag, "_n2_addr"}, mem_address,    p1[16:2]);
        check({tag, "_n2_valid"}, inst_valid,    1'b0);
        next_cycle;
        sample;
        check_inst({tag, "_n3"}, exp_pc);
        next_cycle;
        sample;
        check_inst({tag, "_n4"}, exp_pc + 32'd4);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int issues;
        int unstable;

        // Basic fetch from reset with consumer always ready
        start_reset(1'b1);
        sample;
        check("c0_cs",    mem_chipselect, 1'b1);
        check("c0_addr",  mem_address,    15'h0);
        check("c0_valid", inst_valid,     1'b0);
        next_cycle; sample;
        check("c1_cs",    mem_chipselect, 1'b1);
        check("c1_addr",  mem_address,    15'h1);
        check("c1_valid", inst_valid,     1'b0);
        for (int k = 0; k < 4; k++) begin
            next_cycle; sample;
            check_inst("stream", 32'(4 * k));
        end

        // Back-pressure: exactly FIFO_DEPTH issues, stable head, then drain
        start_reset(1'b0);
        issues   = 0;
        unstable = 0;
        for (int k = 0; k < 10; k++) begin
            if (k > 0) next_cycle;
            sample;
            if (mem_chipselect) issues++;
            if (k >= 2 && (inst_valid !== 1'b1 || inst_pc !== 32'h0 ||
                           inst_data !== 32'h13)) unstable++;
        end
        check("stall_issues",   issues,         4);
        check("stall_cs",       mem_chipselect, 1'b0);
        check("stall_unstable", unstable,       0);
        next_cycle;
        inst_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) next_cycle;
            sample;
            check_inst("drain", 32'(4 * k));
        end

        // Redirect with 3 buffered entries and a response in flight
        start_reset(1'b0);
        repeat (3) next_cycle;
        redirect_seq("redir", 32'h0000_0100, 32'h0000_0100);

        // Memory address wrap and 32-bit PC wrap
        redirect_seq("awrap", 32'h0001_FFFC, 32'h0001_FFFC);
        redirect_seq("pwrap", 32'hFFFF_FFFC, 32'hFFFF_FFFC);

`ifdef FETCH_MISALIGN_TRAP_EN
        next_cycle;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0102;
        next_cycle;
        redirect_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) next_cycle;
            sample;
            check("mis_fault", misalign_fault, 1'b1);
            check("mis_cs",    mem_chipselect, 1'b0);
            check("mis_valid", inst_valid,     1'b0);
        end
        redirect_seq("misclr", 32'h0000_0200, 32'h0000_0200);
        check("misclr_fault", misalign_fault, 1'b0);
`else
        redirect_seq("mis", 32'h0000_0102, 32'h0000_0100);
`endif

        // Reset pulse while the buffer is full
        inst_ready = 1'b0;
        repeat (8) next_cycle;
        sample;
        check("full_valid", inst_valid, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_valid", inst_valid,     1'b0);
        check("arst_cs",    mem_chipselect, 1'b0);
`ifdef FETCH_MISALIGN_TRAP_EN
        check("arst_fault", misalign_fault, 1'b0);
`endif
        inst_ready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        sample;
        check("rst2_cs",   mem_chipselect, 1'b1);
        check("rst2_addr", mem_address,    15'h0);
        next_cycle;
        next_cycle; sample;
        check_inst("rst2_c2", 32'h0);
        next_cycle; sample;
        check_inst("rst2_c3", 32'h4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_imem_fetch
`default_nettype wire
